// File: rtl/sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sample_scheduler
// Purpose  : Paces samples out of the Streamer FIFO at a programmed rate and
//            hands them to the PWM/NCO datapath as a constant-cadence stream.
//            Start-up is held off until the FIFO reaches a prime level.
//            Underruns emit a fill sample and are counted for readback.
// Ports    : ipClk / ipReset            clock, async active-low reset
//            ipEnable, ipRateDiv,       run request, sample period - 1,
//            ipPrimeLevel               FIFO level needed to (re)start
//            ipFifoLevel, ipData,       FIFO occupancy, head sample, head valid
//            ipDataValid
//            opDataReady                pop strobe (combinational, tick cycle)
//            opSample, opSampleValid    registered sample and update pulse
//            opState                    0 IDLE, 1 PRIME, 2 RUN, 3 UNDERRUN
//            ipClearCount,              underrun counter clear / saturating
//            opUnderrunCount            underrun entry count
// Config   : SAMPLE_SCHED_HOLD_EN - fill sample repeats the last sample
//            instead of 0 (mid-scale).
// Revision : 1.0 - initial release
// ============================================================================
module sample_scheduler #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 16,
    parameter int LVL_W  = 10
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic              ipEnable,
    input  logic [DIV_W-1:0]  ipRateDiv,
    input  logic [LVL_W-1:0]  ipPrimeLevel,
    input  logic [LVL_W-1:0]  ipFifoLevel,
    input  logic [DATA_W-1:0] ipData,
    input  logic              ipDataValid,
    output logic              opDataReady,
    output logic [DATA_W-1:0] opSample,
    output logic              opSampleValid,
    output logic [1:0]        opState,
    input  logic              ipClearCount,
    output logic [15:0]       opUnderrunCount
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] w_sample_nxt;
    logic [DATA_W-1:0] w_fill;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [15:0]       r_ucount;
    logic              w_ready;
    logic              w_underrun;
    logic              w_tick;
    logic              w_primed;

    assign w_tick   = (r_div == '0);
    assign w_primed = (ipFifoLevel >= ipPrimeLevel);

`ifdef SAMPLE_SCHED_HOLD_EN
    assign w_fill = r_sample;
`else
    assign w_fill = '0;
`endif

    // State, divider and output sample registers
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_sample <= w_sample_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // Next-state, divider and pop logic
    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_sample_nxt = r_sample;
        w_valid_nxt  = 1'b0;
        w_ready      = 1'b0;
        w_underrun   = 1'b0;

        if (!ipEnable) begin
            // Disable wins over a coincident tick: no pop, no pulse.
            w_state_nxt  = ST_IDLE;
            w_div_nxt    = '0;
            w_sample_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_div_nxt    = '0;
                    w_sample_nxt = '0;
                    w_state_nxt  = ST_PRIME;
                end
                ST_PRIME: begin
                    w_div_nxt = '0;
                    if (w_primed) begin
                        // Full period before the first tick after RUN entry.
                        w_div_nxt   = ipRateDiv;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_div_nxt = w_tick ? ipRateDiv : r_div - 1'b1;
                    if (w_tick) begin
                        w_ready     = 1'b1;
                        w_valid_nxt = 1'b1;
                        if (ipDataValid) begin
                            w_sample_nxt = ipData;
                        end else begin
                            w_sample_nxt = w_fill;
                            w_underrun   = 1'b1;
                            w_state_nxt  = ST_UNDERRUN;
                        end
                    end
                end
                default: begin // ST_UNDERRUN: divider keeps the cadence
                    w_div_nxt = w_tick ? ipRateDiv : r_div - 1'b1;
                    if (w_tick) begin
                        w_valid_nxt = 1'b1;
                        if (w_primed && ipDataValid) begin
                            w_ready      = 1'b1;
                            w_sample_nxt = ipData;
                            w_state_nxt  = ST_RUN;
                        end else begin
                            w_sample_nxt = w_fill;
                        end
                    end
                end
            endcase
        end
    end

    // Underrun entry counter: saturating, clear has priority
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_ucount <= '0;
        end else if (ipClearCount) begin
            r_ucount <= '0;
        end else if (w_underrun && (r_ucount != 16'hFFFF)) begin
            r_ucount <= r_ucount + 16'd1;
        end
    end

    assign opDataReady     = w_ready;
    assign opSample        = r_sample;
    assign opSampleValid   = r_valid;
    assign opState         = r_state;
    assign opUnderrunCount = r_ucount;

endmodule
`default_nettype wire

// File: tb/tb_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_scheduler
// Purpose  : Directed self-checking bench for sample_scheduler. A small FIFO
//            model feeds the DUT; pops follow opDataReady & ipDataValid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_scheduler;

    localparam int C_DATA_W = 16;
    localparam int C_DIV_W  = 16;
    localparam int C_LVL_W  = 10;

`ifdef SAMPLE_SCHED_HOLD_EN
    localparam bit C_HOLD = 1'b1;
`else
    localparam bit C_HOLD = 1'b0;
`endif

    logic                ipClk;
    logic                ipReset;
    logic                ipEnable;
    logic [C_DIV_W-1:0]  ipRateDiv;
    logic [C_LVL_W-1:0]  ipPrimeLevel;
    logic [C_LVL_W-1:0]  ipFifoLevel;
    logic [C_DATA_W-1:0] ipData;
    logic                ipDataValid;
    logic                opDataReady;
    logic [C_DATA_W-1:0] opSample;
    logic                opSampleValid;
    logic [1:0]          opState;
    logic                ipClearCount;
    logic [15:0]         opUnderrunCount;

    // FIFO model
    logic [C_DATA_W-1:0] mem [0:63];
    int                  wr = 0;
    int                  rd = 0;

    int total = 0;
    int bad   = 0;

    assign ipFifoLevel = C_LVL_W'(wr - rd);
    assign ipDataValid = (wr != rd);
    assign ipData      = mem[rd[5:0]];

    always @(posedge ipClk) begin
        if (opDataReady && ipDataValid) rd <= rd + 1;
    end

    initial ipClk = 1'b0;
    always #5 ipClk = ~ipClk;

    sample_scheduler #(
        .DATA_W (C_DATA_W),
        .DIV_W  (C_DIV_W),
        .LVL_W  (C_LVL_W)
    ) dut (
        .ipClk           (ipClk),
        .ipReset         (ipReset),
        .ipEnable        (ipEnable),
        .ipRateDiv       (ipRateDiv),
        .ipPrimeLevel    (ipPrimeLevel),
        .ipFifoLevel     (ipFifoLevel),
        .ipData          (ipData),
        .ipDataValid     (ipDataValid),
        .opDataReady     (opDataReady),
        .opSample        (opSample),
        .opSampleValid   (opSampleValid),
        .opState         (opState),
        .ipClearCount    (ipClearCount),
        .opUnderrunCount (opUnderrunCount)
    );

    task automatic step();
        @(posedge ipClk);
        #1;
    endtask

    task automatic push(input logic [C_DATA_W-1:0] v);
        mem[wr[5:0]] = v;
        wr = wr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [C_DATA_W-1:0] vals [0:3];
    logic [C_DATA_W-1:0] fill;

    initial begin
        vals[0] = 16'h1000; vals[1] = 16'h2000; vals[2] = 16'h3000; vals[3] = 16'h4000;
        ipReset = 1'b0; ipEnable = 1'b1; ipRateDiv = 16'd3; ipPrimeLevel = 10'd4;
        ipClearCount = 1'b0;
        for (int k = 0; k < 4; k++) push(vals[k]);

        // Reset held with enable and a primed FIFO
        repeat (3) step();
        chk("rst_state", 32'(opState), 32'd0);
        chk("rst_sample", 32'(opSample), 32'd0);
        chk("rst_valid", 32'(opSampleValid), 32'd0);
        chk("rst_ready", 32'(opDataReady), 32'd0);
        chk("rst_count", 32'(opUnderrunCount), 32'd0);

        ipReset = 1'b1;
        step();
        chk("prime_state", 32'(opState), 32'd1);
        step();
        chk("run_state", 32'(opState), 32'd2);
        chk("run_entry_noready", 32'(opDataReady), 32'd0);

        // Rate 3: tick every 4th cycle, samples at T+1
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            chk("tick_ready", 32'(opDataReady), 32'd1);
            step();
            chk("tick_sample", 32'(opSample), 32'(vals[k]));
            chk("tick_valid", 32'(opSampleValid), 32'd1);
            chk("tick_ready_off", 32'(opDataReady), 32'd0);
            step();
            chk("valid_pulse", 32'(opSampleValid), 32'd0);
            step();
            step();
        end

        // FIFO empty on this tick: underrun
        fill = C_HOLD ? 16'h4000 : 16'h0000;
        chk("ur_tick_ready", 32'(opDataReady), 32'd1);
        step();
        chk("ur_state", 32'(opState), 32'd3);
        chk("ur_count", 32'(opUnderrunCount), 32'd1);
        chk("ur_valid", 32'(opSampleValid), 32'd1);
        chk("ur_fill", 32'(opSample), 32'(fill));
        step();
        chk("ur_valid_pulse", 32'(opSampleValid), 32'd0);
        step();
        step();
        chk("ur_tick_noready", 32'(opDataReady), 32'd0);
        step();
        chk("ur_fill2_valid", 32'(opSampleValid), 32'd1);
        chk("ur_fill2", 32'(opSample), 32'(fill));
        chk("ur_count_hold", 32'(opUnderrunCount), 32'd1);
        chk("ur_state2", 32'(opState), 32'd3);

        // Refill to prime level: resume on the next tick with a pop
        push(16'h5000); push(16'h6000); push(16'h7000); push(16'h8000);
        step(); step(); step();
        chk("resume_ready", 32'(opDataReady), 32'd1);
        step();
        chk("resume_state", 32'(opState), 32'd2);
        chk("resume_sample", 32'(opSample), 32'h5000);
        chk("resume_valid", 32'(opSampleValid), 32'd1);

        // Disable on a tick cycle
        step(); step(); step();
        chk("dis_tick_ready", 32'(opDataReady), 32'd1);
        ipEnable = 1'b0;
        #1;
        chk("dis_ready", 32'(opDataReady), 32'd0);
        step();
        chk("dis_state", 32'(opState), 32'd0);
        chk("dis_sample", 32'(opSample), 32'd0);
        chk("dis_valid", 32'(opSampleValid), 32'd0);
        chk("dis_nopop_level", 32'(ipFifoLevel), 32'd3);

        // Rate 0, prime 0: pop every cycle
        ipRateDiv = 16'd0; ipPrimeLevel = 10'd0; ipEnable = 1'b1;
        step();
        chk("r0_prime", 32'(opState), 32'd1);
        step();
        chk("r0_run", 32'(opState), 32'd2);
        chk("r0_ready", 32'(opDataReady), 32'd1);
        step();
        chk("r0_s0", 32'(opSample), 32'h6000);
        chk("r0_v0", 32'(opSampleValid), 32'd1);
        step();
        chk("r0_s1", 32'(opSample), 32'h7000);
        chk("r0_v1", 32'(opSampleValid), 32'd1);
        step();
        chk("r0_s2", 32'(opSample), 32'h8000);
        chk("r0_empty_ready", 32'(opDataReady), 32'd1);
        step();
        chk("r0_ur_state", 32'(opState), 32'd3);
        chk("r0_ur_count", 32'(opUnderrunCount), 32'd2);
        chk("r0_ur_fill", 32'(opSample), C_HOLD ? 32'h8000 : 32'h0);

        // Preload the counter near the top; the run-up itself is covered above
        force dut.r_ucount = 16'hFFFE;
        #1;
        release dut.r_ucount;
        for (int i = 0; i < 3; i++) begin
            push(16'h0100 * 16'(i + 1));
            step();
            chk("sat_run", 32'(opState), 32'd2);
            chk("sat_sample", 32'(opSample), 32'h0100 * 32'(i + 1));
            step();
            chk("sat_ur", 32'(opState), 32'd3);
            chk("sat_count", 32'(opUnderrunCount), 32'hFFFF);
        end

        // Clear coincident with an underrun
        push(16'h0AAA);
        step();
        chk("clr_run", 32'(opState), 32'd2);
        ipClearCount = 1'b1;
        step();
        chk("clr_ur_state", 32'(opState), 32'd3);
        chk("clr_count", 32'(opUnderrunCount), 32'd0);
        ipClearCount = 1'b0;
        step();
        chk("clr_count_hold", 32'(opUnderrunCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
